// File: rtl/idu_queue_pkg.sv
// rtl/idu_queue_pkg.sv - shared opcode, funct and decoded-field constants for the decode stage
package idu_queue_pkg;

    localparam int REG_A_END     = 4;
    localparam int ALU_OP_END    = 3;
    localparam int COM_OP_END    = 2;
    localparam int INST_TYPE_END = 6;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_CALC_IMM = 7'b0010011;
    localparam logic [6:0] OP_CALC_REG = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [ALU_OP_END:0] ALU_OP_ADD = 4'b0000;
    localparam logic [ALU_OP_END:0] ALU_OP_RHS = 4'b1111;
    localparam logic [COM_OP_END:0] COM_OP_ONE = 3'b010;

    // Instruction class; the low three inst_type bits carry class-specific detail.
    typedef enum logic [3:0] {
        INST_NONE   = 4'd0,
        INST_IMM    = 4'd1,
        INST_REG    = 4'd2,
        INST_LOAD   = 4'd3,
        INST_STORE  = 4'd4,
        INST_UPP    = 4'd5,
        INST_AUIPC  = 4'd6,
        INST_JUMP   = 4'd7,
        INST_JUMPR  = 4'd8,
        INST_BRANCH = 4'd9,
        INST_SYSTEM = 4'd10
    } inst_class_e;

endpackage

// File: rtl/idu_queue_decode.sv
// rtl/idu_queue_decode.sv - combinational RV32I(+M) decoder
module idu_decode
    import idu_queue_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input  logic [31:0]            inst,
    output logic [REG_A_END:0]     rd,
    output logic [REG_A_END:0]     rs1,
    output logic [REG_A_END:0]     rs2,
    output logic [XLEN-1:0]        imm,
    output logic [ALU_OP_END:0]    alu_op,
    output logic [COM_OP_END:0]    com_op,
    output logic [3:0]             md_op,
    output logic [INST_TYPE_END:0] inst_type,
    output logic                   illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic            bad;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    // Signed casts widen from inst bit 31 to XLEN.
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    // Field decode; any illegal encoding collapses every field back to its default.
    always_comb begin
        bad       = 1'b0;
        imm       = '0;
        alu_op    = ALU_OP_ADD;
        com_op    = COM_OP_ONE;
        md_op     = 4'b0000;
        inst_type = '0;
        case (opcode)
            OP_CALC_IMM: begin
                imm       = imm_i;
                alu_op    = {inst[30] & (funct3 == F3_SR), funct3};
                inst_type = {INST_IMM, 3'b000};
                if (funct3 == F3_SLL && funct7 != F7_ZERO)
                    bad = 1'b1;
                if (funct3 == F3_SR && funct7 != F7_ZERO && funct7 != F7_ALT)
                    bad = 1'b1;
            end
            OP_CALC_REG: begin
                inst_type = {INST_REG, 3'b000};
                if (funct7 == F7_ZERO)
                    alu_op = {1'b0, funct3};
                else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))
                    alu_op = {1'b1, funct3};
                else if (funct7 == F7_MULDIV && ENABLE_M != 0)
                    md_op = {1'b1, funct3};
                else
                    bad = 1'b1;
            end
            OP_LOAD: begin
                imm       = imm_i;
                inst_type = {INST_LOAD, funct3};
            end
            OP_STORE: begin
                imm       = imm_s;
                inst_type = {INST_STORE, funct3};
            end
            OP_LUI: begin
                imm       = imm_u;
                alu_op    = ALU_OP_RHS;
                inst_type = {INST_UPP, 3'b000};
            end
            OP_AUIPC: begin
                imm       = imm_u;
                inst_type = {INST_AUIPC, 3'b000};
            end
            OP_JAL: begin
                imm       = imm_j;
                inst_type = {INST_JUMP, 3'b000};
            end
            OP_JALR: begin
                imm       = imm_i;
                inst_type = {INST_JUMPR, 3'b000};
            end
            OP_BRANCH: begin
                imm       = imm_b;
                com_op    = funct3;
                inst_type = {INST_BRANCH, 3'b000};
            end
            OP_SYSTEM: begin
                imm       = imm_i;
                alu_op    = {funct3[0], funct3[1], 2'b10};
                inst_type = {INST_SYSTEM, funct3[2], 1'b0, |funct3[1:0]};
            end
            default: bad = 1'b1;
        endcase
        if (inst[1:0] != 2'b11)
            bad = 1'b1;
        if (bad) begin
            imm       = '0;
            alu_op    = ALU_OP_ADD;
            com_op    = COM_OP_ONE;
            md_op     = 4'b0000;
            inst_type = '0;
        end
        illegal = bad;
    end

endmodule

// File: rtl/idu_queue.sv
// rtl/idu_queue.sv - decode stage with a DEPTH-entry decoded-instruction queue
module idu_queue
    import idu_queue_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int ENABLE_M = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [REG_A_END:0]     rd,
    output logic [REG_A_END:0]     rs1,
    output logic [REG_A_END:0]     rs2,
    output logic [XLEN-1:0]        imm,
    output logic [ALU_OP_END:0]    alu_op,
    output logic [COM_OP_END:0]    com_op,
    output logic [3:0]             md_op,
    output logic [INST_TYPE_END:0] inst_type,
    output logic                   illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int REC_W = 2 * XLEN + 3 * (REG_A_END + 1) + (ALU_OP_END + 1)
                         + (COM_OP_END + 1) + 4 + (INST_TYPE_END + 1) + 1;

    logic [REG_A_END:0]     d_rd;
    logic [REG_A_END:0]     d_rs1;
    logic [REG_A_END:0]     d_rs2;
    logic [XLEN-1:0]        d_imm;
    logic [ALU_OP_END:0]    d_alu_op;
    logic [COM_OP_END:0]    d_com_op;
    logic [3:0]             d_md_op;
    logic [INST_TYPE_END:0] d_inst_type;
    logic                   d_illegal;

    logic [REC_W-1:0] mem [DEPTH];
    logic [REC_W-1:0] in_rec;
    logic [REC_W-1:0] head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    idu_decode #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .inst      (in_inst),
        .rd        (d_rd),
        .rs1       (d_rs1),
        .rs2       (d_rs2),
        .imm       (d_imm),
        .alu_op    (d_alu_op),
        .com_op    (d_com_op),
        .md_op     (d_md_op),
        .inst_type (d_inst_type),
        .illegal   (d_illegal)
    );

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    assign in_rec = {in_pc, d_rd, d_rs1, d_rs2, d_imm, d_alu_op, d_com_op,
                     d_md_op, d_inst_type, d_illegal};
    assign head   = out_valid ? mem[rd_ptr] : '0;
    assign {out_pc, rd, rs1, rs2, imm, alu_op, com_op, md_op, inst_type, illegal} = head;

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Decoded record storage; contents are don't-care until counted valid.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= in_rec;
    end

endmodule

// File: tb/tb_idu_queue.sv
// tb/tb_idu_queue.sv - scoreboard bench for idu_queue (XLEN32/M and XLEN64/no-M instances)
module tb_idu_queue;
    import idu_queue_pkg::*;

    typedef struct {
        int          idx;
        logic [63:0] pc;
    } sb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = 32'h0;
    logic [63:0] in_pc = 64'h0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] out_pc_a, imm_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [3:0]  alu_op_a, md_op_a;
    logic [2:0]  com_op_a;
    logic [6:0]  inst_type_a;

    logic        in_ready_b, out_valid_b, illegal_b;
    logic [63:0] out_pc_b, imm_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [3:0]  alu_op_b, md_op_b;
    logic [2:0]  com_op_b;
    logic [6:0]  inst_type_b;

    int n_cmp = 0;
    int n_err = 0;
    sb_t sb[$];
    logic last_acc;
    int   step_cnt = 0;
    logic [63:0] pc_ctr = 64'h1000;

    localparam int N = 14;
    logic [31:0] tbl_inst [N] = '{32'h00500093, 32'h402081B3, 32'h027302B3, 32'hFFC12203,
                                  32'h12345537, 32'hFE209CE3, 32'h00512423, 32'hFFDFF0EF,
                                  32'h00000000, 32'h40309093, 32'h4041D113, 32'h300020F3,
                                  32'hFFFFF397, 32'h00008067};
    logic [63:0] tbl_imm [N] = '{64'd5, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFC,
                                 64'h12345000, 64'hFFFFFFFFFFFFFFF8, 64'd8, 64'hFFFFFFFFFFFFFFFC,
                                 64'd0, 64'd0, 64'h404, 64'h300,
                                 64'hFFFFFFFFFFFFF000, 64'd0};
    logic [3:0]  tbl_alu [N] = '{4'h0, 4'h8, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0,
                                 4'h0, 4'h0, 4'h0, 4'hD, 4'h6, 4'h0, 4'h0};
    logic [2:0]  tbl_com [N] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd2,
                                 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    logic [3:0]  tbl_md  [N] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [6:0]  tbl_type [N] = '{{INST_IMM, 3'b000}, {INST_REG, 3'b000}, {INST_REG, 3'b000},
                                  {INST_LOAD, 3'b010}, {INST_UPP, 3'b000}, {INST_BRANCH, 3'b000},
                                  {INST_STORE, 3'b010}, {INST_JUMP, 3'b000}, 7'd0, 7'd0,
                                  {INST_IMM, 3'b000}, {INST_SYSTEM, 3'b001}, {INST_AUIPC, 3'b000},
                                  {INST_JUMPR, 3'b000}};
    logic        tbl_ill [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    idu_queue #(.XLEN(32), .DEPTH(2), .ENABLE_M(1)) dut_a (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
        .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a), .imm(imm_a), .alu_op(alu_op_a),
        .com_op(com_op_a), .md_op(md_op_a), .inst_type(inst_type_a), .illegal(illegal_a)
    );

    idu_queue #(.XLEN(64), .DEPTH(2), .ENABLE_M(0)) dut_b (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
        .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b), .imm(imm_b), .alu_op(alu_op_b),
        .com_op(com_op_b), .md_op(md_op_b), .inst_type(inst_type_b), .illegal(illegal_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_head(input sb_t e);
        logic [31:0] ins;
        ins = tbl_inst[e.idx];
        check("a_pc", {32'h0, out_pc_a}, {32'h0, e.pc[31:0]});
        check("a_illegal", illegal_a, tbl_ill[e.idx]);
        check("a_imm", {32'h0, imm_a}, {32'h0, tbl_imm[e.idx][31:0]});
        check("a_alu_op", alu_op_a, tbl_alu[e.idx]);
        check("a_com_op", com_op_a, tbl_com[e.idx]);
        check("a_md_op", md_op_a, tbl_md[e.idx]);
        check("a_inst_type", inst_type_a, tbl_type[e.idx]);
        if (!tbl_ill[e.idx]) begin
            check("a_rd", rd_a, ins[11:7]);
            check("a_rs1", rs1_a, ins[19:15]);
            check("a_rs2", rs2_a, ins[24:20]);
        end
        check("b_pc", out_pc_b, e.pc);
        if (e.idx == 2) begin
            check("b_mul_illegal", illegal_b, 1);
            check("b_mul_type", inst_type_b, 0);
            check("b_mul_md_op", md_op_b, 0);
            check("b_mul_alu_op", alu_op_b, ALU_OP_ADD);
            check("b_mul_com_op", com_op_b, COM_OP_ONE);
            check("b_mul_imm", imm_b, 0);
        end else begin
            check("b_illegal", illegal_b, tbl_ill[e.idx]);
            check("b_imm", imm_b, tbl_imm[e.idx]);
            check("b_alu_op", alu_op_b, tbl_alu[e.idx]);
            check("b_inst_type", inst_type_b, tbl_type[e.idx]);
        end
    endtask

    task automatic step(input logic v, input int idx, input logic ordy,
                        input logic fl, input logic rst);
        sb_t e;
        @(negedge clock);
        reset     = rst;
        flush     = fl;
        in_valid  = v;
        in_inst   = tbl_inst[idx];
        in_pc     = pc_ctr;
        out_ready = ordy;
        #1;
        step_cnt++;
        if (out_valid_b !== out_valid_a || in_ready_b !== in_ready_a)
            check("a_b_handshake_agree", {out_valid_b, in_ready_b}, {out_valid_a, in_ready_a});
        if (out_valid_a && ordy && !rst) begin
            if (sb.size() == 0) begin
                check("spurious_pop", 1, 0);
            end else begin
                e = sb.pop_front();
                cmp_head(e);
            end
        end
        last_acc = v && in_ready_a && !fl && !rst;
        if (last_acc) begin
            e.idx = idx;
            e.pc  = pc_ctr;
            sb.push_back(e);
            pc_ctr = pc_ctr + 64'd4;
        end
        if (fl || rst)
            sb.delete();
    endtask

    task automatic send(input int idx, input logic ordy);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step(1'b1, idx, ordy, 1'b0, 1'b0);
            done = last_acc;
        end
        if (!done)
            check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step(1'b0, 0, 1'b1, 1'b0, 1'b0);
            done = (sb.size() == 0) && !out_valid_a;
        end
        if (!done)
            check("drain_timeout", 0, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, out_valid_a, 0);
        check({tag, "_in_ready"}, in_ready_a, 1);
        check({tag, "_imm"}, {32'h0, imm_a}, 0);
        check({tag, "_com_op"}, com_op_a, 0);
        check({tag, "_inst_type"}, inst_type_a, 0);
        check({tag, "_b_pc"}, out_pc_b, 0);
    endtask

    initial begin
        int t0;
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clock); #1;
        check_idle("reset");

        // latency: accepted at one edge, visible right after it
        send(0, 1'b0);
        @(posedge clock); #1;
        check("latency_out_valid", out_valid_a, 1);
        drain();

        // sustained streaming of every table entry
        t0 = step_cnt;
        for (int i = 0; i < N; i++)
            send(i, 1'b1);
        check("throughput_steps", step_cnt - t0, N);
        drain();

        // full queue holds the third instruction, then drains in order
        send(1, 1'b0);
        send(3, 1'b0);
        step(1'b1, 5, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", in_ready_a, 0);
        check("full_third_held", last_acc, 0);
        step(1'b1, 5, 1'b0, 1'b0, 1'b0);
        check("full_still_held", last_acc, 0);
        send(5, 1'b1);
        drain();

        // flush with a full queue and with a single entry plus a new input
        send(6, 1'b0);
        send(7, 1'b0);
        step(1'b1, 9, 1'b0, 1'b1, 1'b0);
        @(posedge clock); #1;
        check_idle("flush_full");
        send(10, 1'b0);
        step(1'b1, 11, 1'b0, 1'b1, 1'b0);
        @(posedge clock); #1;
        check_idle("flush_one");
        send(12, 1'b1);
        drain();

        // reset in the middle of traffic behaves like a flush
        send(13, 1'b0);
        send(4, 1'b0);
        step(1'b1, 2, 1'b0, 1'b0, 1'b1);
        @(posedge clock); #1;
        check_idle("mid_reset");
        send(2, 1'b1);
        drain();

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
